bcd_conv_arbiter: RTL and testbench

Shares one sequential 12-bit binary-to-4-digit-BCD engine (shift-and-add-3) among several display requesters in the sale terminal, such as price, quantity, total and change. It arbitrates round-robin between requesters and sequences the engine one bit per clock. It returns the packed BCD result with a one-cycle done pulse to the winning requester. It replaces multiple combinational converters with one multi-cycle datapath.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_conv_arbiter_dd_step.sv | 23 ++
 rtl/bcd_conv_arbiter.sv | 121 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion arbiter: operand/result widths,
// the invalid markers used by the display decoder, and the FSM state type.
package bcd_pkg;

    localparam int BIN_W  = 12;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;

    // All-ones result tells the display decoder to blank or flag the field
    localparam logic [BCD_W-1:0] BCD_INVALID = 16'hFFFF;
    localparam logic [BIN_W-1:0] BIN_INVALID = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SPECIAL,
        DONE
    } state_t;

    // Double-dabble correction: a digit of 5..9 gets +3 so the following
    // left shift carries correctly into the next decade. Digits never exceed
    // 9 before correction, so the sum always fits in four bits.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit > 4'd4) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_dd_step.sv
// One double-dabble iteration: correct every BCD digit, then shift the
// {bcd, bin} pair left by one so the next binary bit enters the units digit.
module dd_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd_next,
    output logic [BIN_W-1:0] bin_next
);

    logic [BCD_W-1:0] adjusted;

    // Per-digit add-3 correction followed by the combined left shift
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adjusted[i*4 +: 4] = add3(bcd[i*4 +: 4]);
        end
        {bcd_next, bin_next} = {adjusted, bin} << 1;
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential 12-bit to 4-digit BCD engine
// among several display requesters. A normal operand takes one grant cycle,
// twelve shift cycles and one finishing cycle; 12'hFFF is short-circuited to
// the all-ones invalid marker. The cycle in which done is presented is never
// a grant cycle, so a requester reacting to its done pulse on the next edge
// is not served a second time by accident.
module bcd_conv_arbiter #(
    parameter int NREQ   = 4,
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BIN_W-1:0]   bin_in,
    output logic [NREQ-1:0]         done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    import bcd_pkg::*;

    localparam int OW = $clog2(NREQ);
    localparam int CW = OW + 1;
    localparam int RW = 4 * DIGITS;
    localparam logic [OW-1:0]   LAST_REQ = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t             state;
    logic [OW-1:0]      ptr;
    logic [BIN_W-1:0]   opnd;
    logic [RW-1:0]      acc;
    logic [3:0]         count;

    logic               grant_found;
    logic [OW-1:0]      grant_idx;
    logic [CW-1:0]      cand;
    logic [BIN_W-1:0]   grant_opnd;
    logic [RW-1:0]      acc_next;
    logic [BIN_W-1:0]   opnd_next;

    // Round-robin search: first pending request at or above ptr, wrapping at NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!grant_found && req[cand[OW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[OW-1:0];
            end
        end
    end

    assign grant_opnd = bin_in[grant_idx*BIN_W +: BIN_W];

    dd_step u_step (
        .bcd      (acc),
        .bin      (opnd),
        .bcd_next (acc_next),
        .bin_next (opnd_next)
    );

    // Conversion sequencer with registered done/busy/owner/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
            done    <= '0;
            bcd_out <= '0;
            owner   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (done == '0 && grant_found) begin
                        owner <= grant_idx;
                        opnd  <= grant_opnd;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= (grant_opnd == BIN_INVALID) ? SPECIAL : SHIFT;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    opnd  <= opnd_next;
                    count <= count + 4'd1;
                    if (count == 4'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                SPECIAL: begin
                    acc   <= BCD_INVALID;
                    state <= DONE;
                end
                DONE: begin
                    bcd_out <= acc;
                    done    <= ONE_HOT0 << owner;
                    ptr     <= (owner == LAST_REQ) ? '0 : owner + OW'(1);
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for the shared BCD converter: stimulus tasks push the
// expected owner/result for each grant, a monitor pops and compares on every
// done pulse. Expected BCD comes from decimal arithmetic, grant order from a
// simple pending-set/pointer model.
module tb_bcd_conv_arbiter;

    localparam int NREQ  = 4;
    localparam int OW    = 2;
    localparam int LIMIT = 60;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*12-1:0]  bin_in;
    logic [NREQ-1:0]     done;
    logic [15:0]         bcd_out;
    logic [OW-1:0]       owner;
    logic                busy;

    typedef struct {
        int          who;
        logic [15:0] bcd;
    } expect_t;

    expect_t expq[$];
    int      nChecks  = 0;
    int      nFails   = 0;
    int      modelPtr = 0;
    int      opndOf[NREQ];

    bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(12), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .bin_in  (bin_in),
        .done    (done),
        .bcd_out (bcd_out),
        .owner   (owner),
        .busy    (busy)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Decimal digits by plain division; 4095 maps to the invalid marker
    function automatic logic [15:0] toBcd(input int v);
        if (v == 4095) return 16'hFFFF;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Next requester served: first pending one at or after the pointer
    function automatic int nextGrant(input int ptr, input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectGrant(input int who, input int val);
        expect_t e;
        e.who = who;
        e.bcd = toBcd(val);
        expq.push_back(e);
        modelPtr = (who + 1) % NREQ;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done !== '0) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                expect_t e;
                e = expq.pop_front();
                checkOutput("done_vec", 32'(done), 32'(1) << e.who);
                checkOutput("owner", 32'(owner), 32'(e.who));
                checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
                checkOutput("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    // Single request with latency and busy tracking; optional operand change and req drop
    task automatic applyStimulus(input int k, input int val, input int latency,
                                 input int changeAt, input int newVal, input int dropAt);
        int   n;
        logic seen;
        @(posedge clk);
        #1;
        bin_in[k*12 +: 12] = 12'(val);
        req[k] = 1'b1;
        expectGrant(k, val);
        checkOutput("busy_before_grant", 32'(busy), 32'd0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LIMIT) begin
            @(posedge clk);
            n++;
            #1;
            if (n == changeAt) bin_in[k*12 +: 12] = 12'(newVal);
            if (n == dropAt) req[k] = 1'b0;
            @(negedge clk);
            if (done !== '0) seen = 1'b1;
            else checkOutput("busy_running", 32'(busy), 32'd1);
        end
        if (!seen) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL done_timeout: requester %0d no done after %0d cycles, expected at %0d",
                     k, n, latency);
        end
        checkOutput("latency", 32'(n), 32'(latency));
        req[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("bcd_hold", 32'(bcd_out), 32'(toBcd(val)));
    endtask

    // Several requesters at once, each dropping its req on its own done
    task automatic runBatch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int              g;
        int              n;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (mask[k]) begin
                opndOf[k] = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095));
                bin_in[k*12 +: 12] = 12'(opndOf[k]);
            end
        end
        pend = mask;
        while (pend != '0) begin
            g = nextGrant(modelPtr, pend);
            expectGrant(g, opndOf[g]);
            pend[g] = 1'b0;
        end
        req = mask;
        n   = 0;
        while (req != '0 && n < LIMIT * NREQ) begin
            @(negedge clk);
            n++;
            req = req & ~done;
        end
        if (req != '0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL batch_timeout: pending %b after %0d cycles, expected 0000", req, n);
        end
        req = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_batch", 32'(busy), 32'd0);
    endtask

    // Requests 0,1,3 held high: served 0,1,3,0 with done pulses 15 cycles apart
    task automatic testHeld();
        int dones[4];
        int got;
        int n;
        int g;
        @(posedge clk);
        #1;
        opndOf[0] = 11;
        opndOf[1] = 22;
        opndOf[3] = 33;
        bin_in[0*12 +: 12] = 12'd11;
        bin_in[1*12 +: 12] = 12'd22;
        bin_in[3*12 +: 12] = 12'd33;
        for (int i = 0; i < 4; i++) begin
            g = nextGrant(modelPtr, 4'b1011);
            expectGrant(g, opndOf[g]);
        end
        req = 4'b1011;
        got = 0;
        n   = 0;
        while (got < 4 && n < LIMIT * 5) begin
            @(negedge clk);
            n++;
            if (done !== '0) begin
                dones[got] = n;
                got++;
                if (got == 4) req = '0;
            end
        end
        req = '0;
        if (got < 4) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL held_timeout: %0d done pulses seen, expected 4", got);
        end else begin
            checkOutput("held_first_latency", 32'(dones[0] - 1), 32'd14);
            for (int i = 1; i < 4; i++) begin
                checkOutput("held_interval", 32'(dones[i] - dones[i-1]), 32'd15);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_held", 32'(busy), 32'd0);
    endtask

    // Asynchronous reset in the middle of a conversion, then a clean conversion
    task automatic resetMidRun();
        logic seenDone;
        @(posedge clk);
        #1;
        bin_in[2*12 +: 12] = 12'd777;
        req[2] = 1'b1;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = '0;
        expq.delete();
        modelPtr = 0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seenDone = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done !== '0) seenDone = 1'b1;
        end
        checkOutput("no_done_after_reset", 32'(seenDone), 32'd0);
        applyStimulus(3, 2047, 14, 0, 0, 0);
    endtask

    // Safety net so a stuck design can never hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, then randomized traffic
    initial begin
        int k;
        int v;
        rst_n  = 1'b0;
        req    = '0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_done", 32'(done), 32'd0);
        checkOutput("init_bcd", 32'(bcd_out), 32'd0);
        checkOutput("init_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        testHeld();

        applyStimulus(0, 1234, 14, 0, 0, 0);
        applyStimulus(1, 0,    14, 0, 0, 0);
        applyStimulus(2, 999,  14, 0, 0, 0);
        applyStimulus(3, 4094, 14, 0, 0, 0);
        applyStimulus(0, 4095, 3,  0, 0, 0);

        applyStimulus(1, 555, 14, 0, 0, 0);
        runBatch(4'b0011);

        applyStimulus(0, 1234, 14, 5, 4000, 8);

        resetMidRun();

        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, NREQ - 1));
            v = ($urandom_range(0, 5) == 0) ? 4095 : int'($urandom_range(0, 4095));
            applyStimulus(k, v, (v == 4095) ? 3 : 14, 0, 0, 0);
        end

        for (int i = 0; i < 8; i++) begin
            runBatch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
        end

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
